// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, lane geometry and request decode helpers for the load/store unit.
package lsu_pkg;
    localparam int NUM_LANES = 4;
    localparam int LANE_W = 8;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    function automatic size_t to_size(input logic [1:0] s);
        return s == 2'd0 ? SZ_B : s == 2'd1 ? SZ_H : SZ_W;
    endfunction
    function automatic logic misaligned(input size_t sz, input logic [1:0] off);
        return (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'd0);
    endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response handshake and data-RAM signals of the load/store unit.
interface lsu_if #(parameter int ADDR_W = 32, parameter int CPU_WORD = 32);
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [1:0]          req_size;
    logic [ADDR_W-1:0]   req_addr;
    logic [CPU_WORD-1:0] req_wdata;
    logic                mem_en;
    logic                mem_we;
    logic [3:0]          mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [CPU_WORD-1:0] mem_wdata;
    logic [CPU_WORD-1:0] mem_rdata;
    logic                mem_rvalid;
    logic                rsp_valid;
    logic [CPU_WORD-1:0] rsp_data;
    logic                rsp_err;
    logic                stall;
    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata, mem_rvalid,
        output req_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err, stall
    );
    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata, mem_rvalid,
        input  req_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err, stall
    );
endinterface

// File: rtl/lane_align.sv
// lane_align: byte enables, lane-replicated store data and right-justified load data.
module lane_align
    import lsu_pkg::*;
#(
    parameter int CPU_WORD = 32
) (
    input  size_t                size,
    input  logic [1:0]           off,
    input  logic [CPU_WORD-1:0]  wdata,
    input  logic [CPU_WORD-1:0]  rdata,
    output logic [NUM_LANES-1:0] be,
    output logic [CPU_WORD-1:0]  wdata_rep,
    output logic [CPU_WORD-1:0]  rdata_aligned
);
    logic [CPU_WORD-1:0] shifted;
    always_comb begin
        be = size == SZ_B ? NUM_LANES'(4'b0001 << off) :
             size == SZ_H ? NUM_LANES'(4'b0011 << {off[1], 1'b0}) : '1;
        wdata_rep = size == SZ_B ? {NUM_LANES{wdata[LANE_W-1:0]}} :
                    size == SZ_H ? {2{wdata[2*LANE_W-1:0]}} : wdata;
        shifted = rdata >> {off, 3'b000};
        rdata_aligned = size == SZ_B ? CPU_WORD'(shifted[LANE_W-1:0]) :
                        size == SZ_H ? CPU_WORD'(shifted[2*LANE_W-1:0]) : shifted;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding memory-access stage driving the synchronous data RAM.
// Define LSU_MISALIGN_TRAP_EN to fail misaligned half/word accesses instead of forcing alignment.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int CPU_WORD = 32,
    parameter int TIMEOUT  = 15
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    state_t                state_q, state_d;
    logic                  we_q, we_d;
    size_t                 size_q, size_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [CPU_WORD-1:0]   wdata_q, wdata_d;
    logic [CPU_WORD-1:0]   data_q, data_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_LANES-1:0]  be;
    logic [CPU_WORD-1:0]   wdata_rep, rdata_aligned;
    size_t                 req_sz;
    logic [1:0]            req_off;
    logic                  trap, issue, timed_out;

    lane_align #(.CPU_WORD(CPU_WORD)) u_align (
        .size          (size_q),
        .off           (addr_q[1:0]),
        .wdata         (wdata_q),
        .rdata         (bus.mem_rdata),
        .be            (be),
        .wdata_rep     (wdata_rep),
        .rdata_aligned (rdata_aligned)
    );

    always_comb begin
        req_sz = to_size(bus.req_size);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = misaligned(req_sz, bus.req_addr[1:0]);
        req_off = bus.req_addr[1:0];
`else
        trap = 1'b0;
        req_off = req_sz == SZ_B ? bus.req_addr[1:0] :
                  req_sz == SZ_H ? {bus.req_addr[1], 1'b0} : 2'b00;
`endif
        timed_out = cnt_q == CNT_W'(TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !bus.req_valid ? IDLE : trap ? RESP : ISSUE;
            ISSUE:   state_d = we_q ? RESP : WAIT;
            WAIT:    state_d = (bus.mem_rvalid || timed_out) ? RESP : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // Request fields latch on acceptance; data/err hold the pending response until RESP.
    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && bus.req_valid) begin
            we_d    = bus.req_we;
            size_d  = req_sz;
            addr_d  = {bus.req_addr[ADDR_W-1:2], req_off};
            wdata_d = bus.req_wdata;
            data_d  = '0;
            err_d   = trap;
        end
        if (state_q == ISSUE) cnt_d = '0;
        if (state_q == WAIT) begin
            cnt_d  = cnt_q + CNT_W'(1);
            data_d = bus.mem_rvalid ? rdata_aligned : '0;
            err_d  = !bus.mem_rvalid && timed_out;
        end
    end

    always_comb begin
        issue         = state_q == ISSUE;
        bus.req_ready = state_q == IDLE;
        bus.stall     = state_q != IDLE;
        bus.mem_en    = issue;
        bus.mem_we    = issue && we_q;
        bus.mem_be    = issue ? be : '0;
        bus.mem_addr  = issue ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        bus.mem_wdata = issue ? wdata_rep : '0;
        bus.rsp_valid = state_q == RESP;
        bus.rsp_data  = state_q == RESP ? data_q : '0;
        bus.rsp_err   = state_q == RESP && err_q;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: vector table plus response scoreboard for load_store_unit.
module tb_load_store_unit;
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        bit          hold;
        int          exp_en;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] maddr;
        logic [31:0] data;
        logic        err;
        int          lat;
    } vec_t;
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    vec_t tbl[12];

    always #5 clk = ~clk;

    lsu_if bus ();
    load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        exp_t e;
        int en_cnt = 0;
        int en_cyc = -1;
        bit done = 0;
        bit leak = 0;
        bit stall_bad = 0;
        bit busy_bad = 0;
        @(negedge clk);
        chk($sformatf("v%0d ready", idx), 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_size  = v.size;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        sb.push_back('{v.data, v.err, v.lat});
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (!v.hold) bus.req_valid = 1'b0;
            if (bus.stall !== !bus.req_ready) stall_bad = 1;
            if (v.hold && bus.req_ready !== 1'b0) busy_bad = 1;
            if (bus.mem_en) begin
                en_cnt++;
                en_cyc = k;
                chk($sformatf("v%0d mem_be", idx), 32'(bus.mem_be), 32'(v.be));
                chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.maddr);
                chk($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.mwdata);
                chk($sformatf("v%0d mem_we", idx), 32'(bus.mem_we), 32'(v.we));
            end else if (bus.mem_we || bus.mem_be != 0 || bus.mem_addr != 0 || bus.mem_wdata != 0) begin
                leak = 1;
            end
            if (bus.rsp_valid) begin
                done = 1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL v%0d unexpected_rsp: got rsp_valid expected none queued", idx);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d rsp_data", idx), bus.rsp_data, e.data);
                    chk($sformatf("v%0d rsp_err", idx), 32'(bus.rsp_err), 32'(e.err));
                    chk($sformatf("v%0d latency", idx), 32'(k), 32'(e.lat));
                end
            end
            bus.mem_rvalid = v.dly > 0 && en_cyc > 0 && k == en_cyc + v.dly;
            bus.mem_rdata  = bus.mem_rvalid ? v.rdata : 32'hFFFF_0000;
        end
        bus.req_valid  = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d rsp_timeout: got no rsp_valid expected one within 40 cycles", idx);
            sb.delete();
        end
        chk($sformatf("v%0d mem_en_count", idx), 32'(en_cnt), 32'(v.exp_en));
        chk($sformatf("v%0d idle_mem_zero", idx), 32'(leak), 32'd0);
        chk($sformatf("v%0d stall_eq", idx), 32'(stall_bad), 32'd0);
        if (v.hold) chk($sformatf("v%0d busy_not_ready", idx), 32'(busy_bad), 32'd0);
    endtask

    initial begin
        bit bad;
        tbl[0]  = '{1, 2'd0, 32'h13, 32'hAB, 32'h0, 0, 0, 1, 4'b1000, 32'hABAB_ABAB, 32'h10, 32'h0, 0, 2};
        tbl[1]  = '{0, 2'd1, 32'h22, 32'h0, 32'h8765_4321, 1, 0, 1, 4'b1100, 32'h0, 32'h20, 32'h8765, 0, 3};
        tbl[2]  = '{0, 2'd0, 32'h01, 32'h0, 32'hDEAD_BEEF, 1, 1, 1, 4'b0010, 32'h0, 32'h0, 32'hBE, 0, 3};
        tbl[3]  = '{0, 2'd2, 32'h40, 32'h0, 32'h0, 0, 0, 1, 4'b1111, 32'h0, 32'h40, 32'h0, 1, 18};
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[4]  = '{1, 2'd2, 32'h06, 32'h1122_3344, 32'h0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 1, 1};
        tbl[10] = '{0, 2'd1, 32'h23, 32'h0, 32'hA1B2_C3D4, 1, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 1, 1};
`else
        tbl[4]  = '{1, 2'd2, 32'h06, 32'h1122_3344, 32'h0, 0, 0, 1, 4'b1111, 32'h1122_3344, 32'h04, 32'h0, 0, 2};
        tbl[10] = '{0, 2'd1, 32'h23, 32'h0, 32'hA1B2_C3D4, 1, 0, 1, 4'b1100, 32'h0, 32'h20, 32'hA1B2, 0, 3};
`endif
        tbl[5]  = '{1, 2'd1, 32'h02, 32'h1234_BEEF, 32'h0, 0, 0, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 32'h0, 0, 2};
        tbl[6]  = '{0, 2'd0, 32'h03, 32'h0, 32'hDEAD_BEEF, 3, 0, 1, 4'b1000, 32'h0, 32'h0, 32'hDE, 0, 5};
        tbl[7]  = '{0, 2'd1, 32'h00, 32'h0, 32'h1234_5678, 1, 0, 1, 4'b0011, 32'h0, 32'h0, 32'h5678, 0, 3};
        tbl[8]  = '{0, 2'd3, 32'h104, 32'h0, 32'hCAFE_F00D, 2, 0, 1, 4'b1111, 32'h0, 32'h104, 32'hCAFE_F00D, 0, 4};
        tbl[9]  = '{1, 2'd0, 32'h10, 32'h1FF, 32'h0, 0, 0, 1, 4'b0001, 32'hFFFF_FFFF, 32'h10, 32'h0, 0, 2};
        tbl[11] = '{0, 2'd2, 32'h08, 32'h0, 32'h55AA_55AA, 16, 0, 1, 4'b1111, 32'h0, 32'h08, 32'h55AA_55AA, 0, 18};

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset stall", 32'(bus.stall), 32'd0);
        chk("reset mem_en", 32'(bus.mem_en), 32'd0);
        chk("reset mem_be", 32'(bus.mem_be), 32'd0);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_data", bus.rsp_data, 32'd0);

        for (int i = 0; i < 12; i++) run(tbl[i], i);

        // Reset while a load waits in WAIT, then a late mem_rvalid.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h80;
        sb.push_back('{32'h0, 1'b0, 0});
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("rst_wait req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_wait rsp_valid", 32'(bus.rsp_valid), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h1357_9BDF;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.mem_en || !bus.req_ready) bad = 1;
        end
        bus.mem_rvalid = 1'b0;
        chk("late_rvalid ignored", 32'(bad), 32'd0);
        run(tbl[7], 12);

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
